// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ byte-stream requesters.
//   Arbitration is round-robin at packet granularity: the owner keeps the
//   transmitter until it hands over a byte flagged last, or until it sits
//   idle mid-packet for TIMEOUT_CYCLES cycles (0 disables the timeout).
//
// Ports
//   clk_i            system clock, all logic on the rising edge
//   rst_ni           asynchronous active-low reset
//   req_valid_i      per-requester byte available
//   req_data_i       per-requester byte, requester i at [8i+7:8i]
//   req_last_i       per-requester end-of-packet flag, sampled on accept
//   req_ready_o      per-requester accept; a byte moves on valid & ready
//   grant_o          one-hot current owner, zero while idle
//   uart_tx_byte_o   byte for the transmitter, held until the next accept
//   uart_tx_start_o  one-cycle start strobe to the transmitter
//   uart_tx_busy_i   transmitter is shifting a frame
//   timeout_err_o    one-cycle pulse when a grant is revoked by timeout
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | no owner; pick next valid requester from the rr pointer
// S_SEND      | owner granted, waiting for its next byte (timeout runs)
// S_WAIT_BUSY | start issued, waiting for the transmitter to go busy
// S_WAIT_DONE | frame in flight, waiting for the transmitter to finish

module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [7:0]           uart_tx_byte_o,
  output logic                 uart_tx_start_o,
  input  logic                 uart_tx_busy_i,
  output logic                 timeout_err_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // The counter never needs to exceed TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [7:0]         byte_q, byte_d;
  logic               start_q, start_d;
  logic               tmo_q, tmo_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic               own_valid;
  logic [7:0]         own_data;
  logic               own_last;

  // Increment modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (32'(idx) == NUM_REQ - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  assign own_valid = req_valid_i[gidx_q];
  assign own_data  = req_data_i[8*gidx_q +: 8];
  assign own_last  = req_last_i[gidx_q];

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    byte_d  = byte_q;
    start_d = 1'b0;
    tmo_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          gidx_d  = pick_idx;
          cnt_d   = '0;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (own_valid) begin
          byte_d  = own_data;
          start_d = 1'b1;
          last_d  = own_last;
          state_d = S_WAIT_BUSY;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          // Stalled owner loses the grant and drops to lowest priority.
          tmo_d   = 1'b1;
          ptr_d   = wrap_inc(gidx_q);
          state_d = S_IDLE;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_BUSY: begin
        if (uart_tx_busy_i) begin
          state_d = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (!uart_tx_busy_i) begin
          if (last_q) begin
            ptr_d   = wrap_inc(gidx_q);
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_SEND;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      byte_q  <= 8'h00;
      start_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
    end
  end

  // Grant is derived from the state so reset clears it immediately.
  always_comb begin
    grant_o = '0;
    if (state_q != S_IDLE) begin
      grant_o[gidx_q] = 1'b1;
    end
  end

  assign req_ready_o     = (state_q == S_SEND) ? grant_o : '0;
  assign uart_tx_byte_o  = byte_q;
  assign uart_tx_start_o = start_q;
  assign timeout_err_o   = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   v_valid, v_last;
  logic [8*N-1:0] v_data;
  logic           v_busy;
  logic [N-1:0]   req_ready, grant;
  logic [7:0]     tx_byte;
  logic           tx_start, tmo;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (v_valid),
    .req_data_i     (v_data),
    .req_last_i     (v_last),
    .req_ready_o    (req_ready),
    .grant_o        (grant),
    .uart_tx_byte_o (tx_byte),
    .uart_tx_start_o(tx_start),
    .uart_tx_busy_i (v_busy),
    .timeout_err_o  (tmo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the transmitter and where its frame stands.
  //   m_owner -1 when nobody holds the transmitter
  //   m_phase 0 owner may hand a byte, 1 byte handed/frame not started,
  //           2 frame being shifted
  int         m_owner, m_ptr, m_phase, m_stall;
  bit         m_last, m_start, m_tmo;
  logic [7:0] m_byte;
  logic [N-1:0] acc_mask;
  int         n_start, n_tmo;
  int         gnt_log[$];
  logic [N-1:0] prev_gnt;
  bit         auto_prod;
  int         sleep_c[N];
  int         busy_cnt;
  bit         prev_start;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_phase = 0; m_stall = 0;
    m_last = 0; m_byte = 8'h00; m_start = 0; m_tmo = 0;
    prev_start = 0; v_busy = 0; busy_cnt = 0;
    v_valid = '0; v_last = '0; prev_gnt = '0;
  endtask

  task automatic step();
    int c;
    logic [N-1:0] exp_g, exp_r;
    @(posedge clk);
    #1;
    acc_mask = '0; m_start = 0; m_tmo = 0;
    if (m_owner < 0) begin
      if (v_valid != '0) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (v_valid[c]) begin
            m_owner = c;
            break;
          end
        end
        m_phase = 0; m_stall = 0;
      end
    end else if (m_phase == 0) begin
      if (v_valid[m_owner]) begin
        acc_mask[m_owner] = 1'b1;
        m_byte  = v_data[8*m_owner +: 8];
        m_last  = v_last[m_owner];
        m_start = 1;
        m_phase = 1;
      end else begin
        m_stall++;
        if (m_stall == T) begin
          m_tmo   = 1;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end else if (m_phase == 1) begin
      if (v_busy) m_phase = 2;
    end else if (!v_busy) begin
      if (m_last) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_phase = 0;
        m_stall = 0;
      end
    end

    exp_g = '0;
    if (m_owner >= 0) exp_g[m_owner] = 1'b1;
    exp_r = (m_owner >= 0 && m_phase == 0) ? exp_g : '0;
    chk("grant", grant, exp_g);
    chk("ready", req_ready, exp_r);
    chk("start", tx_start, m_start);
    chk("byte", tx_byte, m_byte);
    chk("timeout_err", tmo, m_tmo);

    if (tx_start) n_start++;
    if (tmo) n_tmo++;
    if (prev_gnt == '0 && grant != '0) begin
      for (int i = 0; i < N; i++) if (grant[i]) gnt_log.push_back(i);
    end
    prev_gnt = grant;

    // Transmitter: goes busy the cycle after a start, for 1..6 cycles.
    if (prev_start) begin
      v_busy = 1'b1;
      busy_cnt = $urandom_range(1, 6);
    end else if (v_busy) begin
      busy_cnt--;
      if (busy_cnt == 0) v_busy = 1'b0;
    end
    prev_start = m_start;

    if (auto_prod) begin
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            v_valid[i] = 1'b0;
            sleep_c[i] = $urandom_range(0, 4);
          end else begin
            v_data[8*i +: 8] = 8'($urandom);
            v_last[i] = ($urandom_range(0, 2) == 0);
          end
        end else if (!v_valid[i]) begin
          if (sleep_c[i] > 0) sleep_c[i]--;
          else if ($urandom_range(0, 3) == 0) begin
            v_valid[i] = 1'b1;
            v_data[8*i +: 8] = 8'($urandom);
            v_last[i] = ($urandom_range(0, 2) == 0);
          end
        end else if ($urandom_range(0, 29) == 0) begin
          v_valid[i] = 1'b0;
          sleep_c[i] = $urandom_range(1, 30);
        end else begin
          v_last[i] = $urandom_range(0, 1);
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_owner >= 0 && n < 200) begin
      step();
      n++;
    end
    chk("idle_grant", grant, 0);
  endtask

  task automatic send_packet(input int r, input logic [7:0] base, input int n, input bit end_last);
    bit got;
    for (int k = 0; k < n; k++) begin
      v_valid[r] = 1'b1;
      v_data[8*r +: 8] = 8'(base + k);
      v_last[r] = end_last && (k == n - 1);
      got = 0;
      for (int w = 0; w < 100 && !got; w++) begin
        step();
        if (acc_mask[r]) got = 1;
      end
      chk("accept_bound", got, 1);
      v_valid[r] = 1'b0;
      v_last[r] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, s0, t0, stall_cnt;
    bit done2, seen, got;
    v_data = '0; auto_prod = 0; n_start = 0; n_tmo = 0;
    for (int i = 0; i < N; i++) sleep_c[i] = 0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_byte", tx_byte, 0);
    chk("rst_tmo", tmo, 0);
    rst_n = 1'b1;
    step();

    // req1 and req2 together with pointer 0: req1 first, req2 blocked meanwhile
    gnt_log.delete();
    v_data[15:8] = 8'hA1; v_data[23:16] = 8'hB1;
    v_valid[1] = 1; v_valid[2] = 1; v_last[1] = 0; v_last[2] = 1;
    acc1 = 0; done2 = 0;
    for (int cyc = 0; cyc < 200 && !done2; cyc++) begin
      step();
      if (grant[1]) chk("t6_ready2_blocked", req_ready[2], 0);
      if (acc_mask[1]) begin
        acc1++;
        v_data[15:8] = 8'hA2;
        v_last[1] = 1;
        if (acc1 == 2) begin v_valid[1] = 0; v_last[1] = 0; end
      end
      if (acc_mask[2]) begin v_valid[2] = 0; v_last[2] = 0; done2 = 1; end
    end
    chk("t2_done", done2, 1);
    wait_idle();
    chk("t2_first", gnt_log[0], 1);
    chk("t2_second", gnt_log[1], 2);

    // Pointer now at 3: req3 wins over req1
    gnt_log.delete();
    v_valid[1] = 1; v_valid[3] = 1; v_last[1] = 1; v_last[3] = 1;
    for (int cyc = 0; cyc < 200 && (v_valid[1] || v_valid[3]); cyc++) begin
      step();
      if (acc_mask[1]) begin v_valid[1] = 0; v_last[1] = 0; end
      if (acc_mask[3]) begin v_valid[3] = 0; v_last[3] = 0; end
    end
    wait_idle();
    chk("t2_rr_a", gnt_log[0], 3);
    chk("t2_rr_b", gnt_log[1], 1);

    // req0 three-byte packet
    s0 = n_start;
    send_packet(0, 8'h41, 3, 1);
    wait_idle();
    chk("t1_starts", n_start - s0, 3);

    // req3 stalls mid-packet, req0 waiting
    v_valid[0] = 1; v_data[7:0] = 8'h10; v_last[0] = 1;
    t0 = n_tmo;
    send_packet(3, 8'h55, 1, 0);
    stall_cnt = 0; seen = 0;
    for (int w = 0; w < 60 && !seen; w++) begin
      step();
      if (req_ready[3]) stall_cnt++;
      if (tmo) seen = 1;
    end
    chk("t3_tmo_seen", seen, 1);
    chk("t3_stall_len", stall_cnt, T);
    chk("t3_tmo_count", n_tmo - t0, 1);
    step();
    chk("t3_next_grant", grant, 4'b0001);
    got = 0;
    for (int w = 0; w < 20 && !got; w++) begin
      if (acc_mask[0]) got = 1;
      else step();
    end
    v_valid[0] = 0; v_last[0] = 0;
    wait_idle();

    // All four valid, single-byte packets
    gnt_log.delete();
    v_valid = '1; v_last = '1;
    for (int cyc = 0; cyc < 400 && gnt_log.size() < 9; cyc++) begin
      step();
      for (int i = 0; i < N; i++) if (acc_mask[i]) v_data[8*i +: 8] = 8'($urandom);
    end
    v_valid = '0; v_last = '0;
    for (int j = 1; j < 9; j++) chk("t4_rr", gnt_log[j], (gnt_log[j-1] + 1) % N);
    wait_idle();

    // Reset while a frame is in flight
    v_valid[2] = 1; v_data[23:16] = 8'h77; v_last[2] = 0;
    for (int w = 0; w < 50 && !(m_owner >= 0 && m_phase == 2); w++) step();
    chk("t5_in_frame", grant, 4'b0100);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_start", tx_start, 0);
    chk("t5_rst_byte", tx_byte, 0);
    chk("t5_rst_ready", req_ready, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v_valid = '1; v_last = '1;
    step();
    chk("t5_restart", grant, 4'b0001);
    v_valid = '0; v_last = '0;
    wait_idle();

    // Random traffic
    auto_prod = 1;
    repeat (3000) step();
    auto_prod = 0;
    v_valid = '0; v_last = '0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
